// File: rtl/rom_cpu_pkg.sv
// Shared definitions for the ROM-fed accumulator CPU: opcodes, instruction fields, FSM states.
// Optional carry flag / JC opcode is built in when ROM_CPU_CARRY_EN is defined.
package rom_cpu_pkg;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RSV_MSB = 11;
   localparam int RSV_LSB = 10;
   localparam int RD_MSB  = 9;
   localparam int RD_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_MOVI = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_XORI = 4'h3;
   localparam logic [3:0] OP_ANDI = 4'h4;
   localparam logic [3:0] OP_JZ   = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JNZ  = 4'h7;
   localparam logic [3:0] OP_JC   = 4'h8;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

endpackage

// File: rtl/rom_cpu_alu.sv
// Combinational ALU for MOVI/ADDI/XORI/ANDI; zero latency, no flow control.
// The carry output exists only when ROM_CPU_CARRY_EN is defined.
module rom_cpu_alu
   import rom_cpu_pkg::*;
(
   input  logic [3:0] op,
   input  logic [7:0] rd_val,
   input  logic [7:0] imm,
   output logic [7:0] result,
   output logic       result_vld,
   output logic       zero
`ifdef ROM_CPU_CARRY_EN
   ,
   output logic       carry
`endif
);

`ifdef ROM_CPU_CARRY_EN
   logic [8:0] sum;
   assign sum   = {1'b0, rd_val} + {1'b0, imm};
   // Only ADDI can produce a carry; the other ALU ops clear it.
   assign carry = (op == OP_ADDI) & sum[8];
`else
   logic [7:0] sum;
   assign sum = rd_val + imm;
`endif

   always_comb begin
      result     = rd_val;
      result_vld = 1'b0;
      case (op)
         OP_MOVI: begin result = imm;           result_vld = 1'b1; end
         OP_ADDI: begin result = sum[7:0];      result_vld = 1'b1; end
         OP_XORI: begin result = rd_val ^ imm;  result_vld = 1'b1; end
         OP_ANDI: begin result = rd_val & imm;  result_vld = 1'b1; end
         default: ;
      endcase
      zero = (result == 8'h00);
   end

endmodule

// File: rtl/rom_cpu_core.sv
// 8-bit accumulator CPU: FETCH/EXEC FSM, 2 cycles per instruction, run_en=0 stalls all state.
// Optional carry flag and JC opcode enabled by ROM_CPU_CARRY_EN.
module rom_cpu_core
   import rom_cpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC      = 8'h00,
   parameter bit         HALT_ON_UNDEF = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_en,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_data,
   input  logic [1:0]  dbg_sel,
   output logic [7:0]  dbg_data,
   output logic        zero_flag,
   output logic        halted,
   output logic        retire
`ifdef ROM_CPU_CARRY_EN
   ,
   output logic        carry_flag
`endif
);

   state_e          state, next_state;
   logic [7:0]      pc;
   logic [15:0]     ir;
   logic [3:0][7:0] regs;
   logic            z;
   logic [3:0]      op;
   logic [1:0]      rd;
   logic [7:0]      imm;
   logic            jump, undef, halt_now;
   logic [7:0]      alu_result;
   logic            alu_vld, alu_zero;
   logic            ir_unused;

   assign op        = ir[OP_MSB:OP_LSB];
   assign rd        = ir[RD_MSB:RD_LSB];
   assign imm       = ir[IMM_MSB:IMM_LSB];
   assign ir_unused = ^ir[RSV_MSB:RSV_LSB];

`ifdef ROM_CPU_CARRY_EN
   logic c;
   logic alu_carry;
   assign carry_flag = c;
`endif

   rom_cpu_alu u_alu (
      .op         (op),
      .rd_val     (regs[rd]),
      .imm        (imm),
      .result     (alu_result),
      .result_vld (alu_vld),
      .zero       (alu_zero)
`ifdef ROM_CPU_CARRY_EN
      ,
      .carry      (alu_carry)
`endif
   );

   always_comb begin
      jump       = 1'b0;
      undef      = 1'b0;
      next_state = state;
      retire     = 1'b0;
      case (op)
         OP_NOP, OP_MOVI, OP_ADDI, OP_XORI, OP_ANDI, OP_HLT: ;
         OP_JZ:  jump = z;
         OP_JMP: jump = 1'b1;
         OP_JNZ: jump = ~z;
`ifdef ROM_CPU_CARRY_EN
         OP_JC:  jump = c;
`endif
         default: undef = 1'b1;
      endcase
      halt_now = (op == OP_HLT) || (undef && HALT_ON_UNDEF);
      case (state)
         ST_FETCH: next_state = ST_EXEC;
         ST_EXEC: begin
            retire     = run_en;
            next_state = halt_now ? ST_HALT : ST_FETCH;
         end
         ST_HALT:  next_state = ST_HALT;
         default:  next_state = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         regs  <= '0;
         z     <= 1'b0;
`ifdef ROM_CPU_CARRY_EN
         c     <= 1'b0;
`endif
      end else if (run_en) begin
         state <= next_state;
         if (state == ST_FETCH)
            ir <= rom_data;
         if (state == ST_EXEC) begin
            // A halting instruction leaves PC pointing at itself.
            if (!halt_now)
               pc <= jump ? imm : pc + 8'd1;
            if (alu_vld) begin
               regs[rd] <= alu_result;
               z        <= alu_zero;
`ifdef ROM_CPU_CARRY_EN
               c        <= alu_carry;
`endif
            end
         end
      end
   end

   assign rom_addr  = pc;
   assign dbg_data  = regs[dbg_sel];
   assign zero_flag = z;
   assign halted    = (state == ST_HALT);

endmodule

// File: doc/rom_cpu_core.md
Name: rom_cpu_core

Overview:
- Minimal 8-bit accumulator-style CPU that consumes the 16-bit instruction word from the 256x16 combinational program ROM.
- Drives the ROM address (PC), latches the returned word, decodes and executes it.
- Holds four 8-bit registers and a zero flag, and reports halt status to the test top.
- Directly downstream of the program ROM; the ROM data path is combinational, so the read completes in the same cycle the address is driven.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_UNDEF, 0, 1 = undefined opcode halts the core; 0 = undefined opcode executes as NOP.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run_en  in  1  0 = freeze the FSM and all state in place (stall); 1 = run.
- rom_addr  out  8  instruction address (equals PC).
- rom_data  in  16  instruction word from the ROM.
- dbg_sel  in  2  register select for the debug read.
- dbg_data  out  8  combinational read of R[dbg_sel].
- zero_flag  out  1  current Z.
- halted  out  1  high once HLT has executed; sticky until reset.
- retire  out  1  one-cycle pulse on every EXEC cycle.

Behaviour:
- Instruction encoding:
  - [15:12] opcode; [9:8] reg_sel (rd); [7:0] imm8/addr8; [11:10] ignored.
- Opcodes:
  - 0 NOP.
  - 1 MOVI: rd = imm.
  - 2 ADDI: rd = rd + imm, mod 256.
  - 3 XORI: rd = rd ^ imm.
  - 4 ANDI: rd = rd & imm.
  - 5 JZ: if Z, PC = addr8.
  - 6 JMP: PC = addr8.
  - 7 JNZ: if !Z, PC = addr8.
  - F HLT.
  - 8..E: undefined, handled per HALT_ON_UNDEF.
- Z update rule: MOVI, ADDI, XORI and ANDI set Z = (result == 0). All other instructions leave Z unchanged.
- FSM has three states: FETCH, EXEC, HALT.
  - FETCH: IR <= rom_data; go to EXEC.
  - EXEC: apply the instruction. PC <= jump target if the jump is taken, else PC + 1 (wraps 8'hFF to 8'h00). retire = 1. Go to FETCH, or to HALT for HLT or a halting undefined opcode.
  - HALT: PC, registers and Z frozen; halted = 1; only rst leaves.
- Timing: every instruction takes exactly 2 cycles. rom_addr = PC at all times.
- run_en = 0: no state change and retire = 0. Resuming continues exactly where the core stopped.
- Reset values (rst sampled high on a clock edge): PC = RESET_PC; R0..R3 = 0; Z = 0; IR = 0; state = FETCH; halted = 0; retire = 0.
- rst takes priority over run_en and over any state, including mid-EXEC and HALT.
- A jump target equal to PC (self-loop) is legal and spins indefinitely.

Optional Feature:
- Macro: ROM_CPU_CARRY_EN.
- When defined:
  - Adds carry flag C (reset 0) and output port carry_flag.
  - ADDI sets C = bit 8 of the 9-bit sum.
  - MOVI, XORI and ANDI clear C.
  - Opcode 8 = JC: if C, PC = addr8.
- When not defined: no C register and no carry_flag port; opcode 8 is undefined.

Decomposition:
- Shared package/header holds:
  - opcode constants (OP_NOP..OP_HLT, OP_JC);
  - field bit positions;
  - FSM state encodings.
- One natural sub-module, rom_cpu_alu: combinational; inputs op, rd value and imm; outputs result, result-valid, zero and carry. The core keeps the FSM, PC, IR and register file.

Test Plan:
- Sample program: ROM at 00..06 = 1005, 2007, 300F, 20FD, 5006, 1155, F000. After rst, run 12 cycles → halted = 1; R0 = 00; R1 = 00 (instruction at 05 skipped); Z = 1; PC = 06; exactly 6 retire pulses.
- Intermediate R0 values in the same run: 05, 0C, 03, 00 after the 1st–4th EXEC. With ROM_CPU_CARRY_EN, C = 1 after the 4th EXEC.
- Stall: toggle run_en low for 3 cycles in the middle of the sample program → identical final state; halt occurs 3 cycles later; no retire while stalled.
- Wrap and JNZ: RESET_PC = FF with NOP at FF → PC wraps to 00. Program MOVI R2,1 ; JNZ 00 → loops; R2 stays 01 and Z stays 0.
- Undefined opcode 9xxx: HALT_ON_UNDEF = 0 → PC advances; HALT_ON_UNDEF = 1 → halted after its EXEC.
- Reset mid-run: assert rst during the EXEC of ADDI → next cycle PC = RESET_PC, all registers 0, Z = 0, halted = 0. Rerunning reproduces the results of the sample-program scenario.
